// File: rtl/m_axi4_fsb_reader.sv
// Reads a host-memory ring of 64-byte lines over an AXI4 read channel and unpacks
// each line into up to four FSB packets on a valid/yumi output.
module m_axi4_fsb_reader #(
    parameter int unsigned fsb_width_p     = 80,
    parameter int unsigned axi4_width_p    = 512,
    parameter int unsigned addr_width_p    = 64,
    parameter int unsigned id_width_p      = 6,
    parameter int unsigned ring_lg_lines_p = 10,
    parameter int unsigned burst_len_p     = 4,
    parameter int unsigned fifo_els_p      = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        cfg_en_i,
    input  logic [addr_width_p-1:0]     cfg_base_addr_i,
    input  logic [ring_lg_lines_p:0]    cfg_wr_ptr_i,
    output logic [ring_lg_lines_p:0]    rd_ptr_o,
    output logic                        err_o,

    // AXI4 master: read address channel
    output logic [id_width_p-1:0]       m_axi_arid_o,
    output logic [addr_width_p-1:0]     m_axi_araddr_o,
    output logic [7:0]                  m_axi_arlen_o,
    output logic [2:0]                  m_axi_arsize_o,
    output logic [1:0]                  m_axi_arburst_o,
    output logic                        m_axi_arvalid_o,
    input  logic                        m_axi_arready_i,
    // AXI4 master: read data channel
    input  logic [id_width_p-1:0]       m_axi_rid_i,
    input  logic [axi4_width_p-1:0]     m_axi_rdata_i,
    input  logic [1:0]                  m_axi_rresp_i,
    input  logic                        m_axi_rlast_i,
    input  logic                        m_axi_rvalid_i,
    output logic                        m_axi_rready_o,
    // AXI4 master: write channels, unused by this reader
    output logic [id_width_p-1:0]       m_axi_awid_o,
    output logic [addr_width_p-1:0]     m_axi_awaddr_o,
    output logic [7:0]                  m_axi_awlen_o,
    output logic [2:0]                  m_axi_awsize_o,
    output logic [1:0]                  m_axi_awburst_o,
    output logic                        m_axi_awvalid_o,
    input  logic                        m_axi_awready_i,
    output logic [axi4_width_p-1:0]     m_axi_wdata_o,
    output logic [axi4_width_p/8-1:0]   m_axi_wstrb_o,
    output logic                        m_axi_wlast_o,
    output logic                        m_axi_wvalid_o,
    input  logic                        m_axi_wready_i,
    input  logic [id_width_p-1:0]       m_axi_bid_i,
    input  logic [1:0]                  m_axi_bresp_i,
    input  logic                        m_axi_bvalid_i,
    output logic                        m_axi_bready_o,

    output logic                        fsb_v_o,
    output logic [fsb_width_p-1:0]      fsb_data_o,
    input  logic                        fsb_yumi_i
);

    localparam int unsigned PtrW  = ring_lg_lines_p + 1;
    localparam int unsigned IdxW  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int unsigned CntW  = $clog2(fifo_els_p + 1);
    localparam int unsigned Slots = axi4_width_p / 128;
    localparam int unsigned SelW  = $clog2(Slots);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StErr} state_e;

    state_e                     r_state;
    logic                       r_arvalid;
    logic                       r_rready;
    logic [addr_width_p-1:0]    r_araddr;
    logic [7:0]                 r_arlen;
    logic [PtrW-1:0]            r_len;
    logic [PtrW-1:0]            r_rd_ptr;
    logic                       r_err;

    logic [axi4_width_p-1:0]    r_mem [fifo_els_p];
    logic [IdxW-1:0]            r_wr_idx;
    logic [IdxW-1:0]            r_rd_idx;
    logic [CntW-1:0]            r_count;

    // r_loaded: r_mask holds the remaining valid slots of the FIFO head line
    logic                       r_loaded;
    logic [Slots-1:0]           r_mask;

    logic [PtrW-1:0]            w_avail;
    logic [ring_lg_lines_p-1:0] w_ring_idx;
    logic [PtrW-1:0]            w_ring_room;
    logic [PtrW-1:0]            w_page_room;
    logic [PtrW-1:0]            w_len;
    logic [CntW-1:0]            w_free;
    logic                       w_issue;
    logic                       w_beat;
    logic                       w_bad;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_done;
    logic [IdxW-1:0]            w_wr_idx_inc;
    logic [IdxW-1:0]            w_rd_idx_inc;
    logic [axi4_width_p-1:0]    w_head;
    logic [axi4_width_p-1:0]    w_next;
    logic [Slots-1:0]           w_head_vld;
    logic [Slots-1:0]           w_next_vld;
    logic [SelW-1:0]            w_sel;
    logic [Slots-1:0]           w_rem;
    logic                       w_unused;

    assign w_avail     = cfg_wr_ptr_i - r_rd_ptr;
    assign w_ring_idx  = r_rd_ptr[ring_lg_lines_p-1:0];
    assign w_ring_room = PtrW'(2 ** ring_lg_lines_p) - PtrW'(w_ring_idx);
    // Lines left before the next 4 KB page boundary
    assign w_page_room = PtrW'(64) - PtrW'(w_ring_idx[5:0]);
    assign w_free      = CntW'(fifo_els_p) - r_count;

    // Burst length: smallest of cap, available lines, ring end and page end
    always_comb begin
        w_len = PtrW'(burst_len_p);
        if (w_avail < w_len)     w_len = w_avail;
        if (w_ring_room < w_len) w_len = w_ring_room;
        if (w_page_room < w_len) w_len = w_page_room;
    end

    assign w_issue = cfg_en_i && (w_avail != '0) && (32'(w_len) <= 32'(w_free)) && !r_err;
    assign w_beat  = m_axi_rvalid_i && r_rready;
    assign w_bad   = (m_axi_rresp_i != 2'b00);
    assign w_push  = w_beat;

    // Fetch FSM: one burst in flight, FIFO space reserved at issue
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= StIdle;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_len     <= '0;
            r_rd_ptr  <= '0;
            r_err     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_issue) begin
                        r_state   <= StAddr;
                        r_arvalid <= 1'b1;
                        r_araddr  <= cfg_base_addr_i + (addr_width_p'(w_ring_idx) << 6);
                        r_arlen   <= 8'(w_len - PtrW'(1));
                        r_len     <= w_len;
                    end
                end
                StAddr: begin
                    if (m_axi_arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= StData;
                    end
                end
                StData: begin
                    if (w_beat) begin
                        if (w_bad) r_err <= 1'b1;
                        if (m_axi_rlast_i) begin
                            r_rready <= 1'b0;
                            if (r_err || w_bad) begin
                                r_state <= StErr;
                            end else begin
                                r_rd_ptr <= r_rd_ptr + r_len;
                                r_state  <= StIdle;
                            end
                        end
                    end
                end
                StErr: begin
                    if (!cfg_en_i) begin
                        r_err   <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_wr_idx_inc = (r_wr_idx == IdxW'(fifo_els_p - 1)) ? '0 : r_wr_idx + 1'b1;
    assign w_rd_idx_inc = (r_rd_idx == IdxW'(fifo_els_p - 1)) ? '0 : r_rd_idx + 1'b1;

    // Line storage; no reset needed, occupancy is tracked by r_count
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_idx] <= m_axi_rdata_i;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_idx <= w_wr_idx_inc;
            if (w_pop)  r_rd_idx <= w_rd_idx_inc;
            if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
        end
    end

    assign w_head = r_mem[r_rd_idx];
    assign w_next = r_mem[w_rd_idx_inc];

    // Slot valid flags of the head line and the one behind it
    always_comb begin
        for (int i = 0; i < Slots; i++) begin
            w_head_vld[i] = w_head[128*i + 127];
            w_next_vld[i] = w_next[128*i + 127];
        end
    end

    // Find-next-valid: lowest pending slot
    always_comb begin
        w_sel = '0;
        for (int i = Slots - 1; i >= 0; i--) begin
            if (r_mask[i]) w_sel = SelW'(i);
        end
        w_rem        = r_mask;
        w_rem[w_sel] = 1'b0;
    end

    // Head line finished: either loaded with nothing pending, or last slot taken
    assign w_done = r_loaded && ((r_mask == '0) || (fsb_yumi_i && (w_rem == '0)));
    // Unloaded empty head lines are dropped without ever being loaded
    assign w_pop  = w_done || (!r_loaded && (r_count != '0) && (w_head_vld == '0));

    // Unpacker: loads the head mask, retires slots on yumi, looks ahead on line change
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_loaded <= 1'b0;
            r_mask   <= '0;
        end else if (w_done) begin
            if (r_count >= CntW'(2)) begin
                r_loaded <= 1'b1;
                r_mask   <= w_next_vld;
            end else begin
                r_loaded <= 1'b0;
                r_mask   <= '0;
            end
        end else if (r_loaded) begin
            if (fsb_yumi_i && fsb_v_o) r_mask <= w_rem;
        end else if ((r_count != '0) && (w_head_vld != '0)) begin
            r_loaded <= 1'b1;
            r_mask   <= w_head_vld;
        end
    end

    assign fsb_v_o    = |r_mask;
    assign fsb_data_o = fsb_v_o ? w_head[{w_sel, 7'd0} +: fsb_width_p] : '0;

    assign rd_ptr_o        = r_rd_ptr;
    assign err_o           = r_err;
    assign m_axi_arid_o    = '0;
    assign m_axi_araddr_o  = r_araddr;
    assign m_axi_arlen_o   = r_arlen;
    assign m_axi_arsize_o  = 3'd6;
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arvalid_o = r_arvalid;
    assign m_axi_rready_o  = r_rready;

    assign m_axi_awid_o    = '0;
    assign m_axi_awaddr_o  = '0;
    assign m_axi_awlen_o   = '0;
    assign m_axi_awsize_o  = '0;
    assign m_axi_awburst_o = '0;
    assign m_axi_awvalid_o = 1'b0;
    assign m_axi_wdata_o   = '0;
    assign m_axi_wstrb_o   = '0;
    assign m_axi_wlast_o   = 1'b0;
    assign m_axi_wvalid_o  = 1'b0;
    assign m_axi_bready_o  = 1'b1;

    assign w_unused = ^{m_axi_rid_i, m_axi_awready_i, m_axi_wready_i, m_axi_bid_i,
                        m_axi_bresp_i, m_axi_bvalid_i, w_head, w_next};

endmodule

// File: tb/tb_m_axi4_fsb_reader.sv
// Directed bench for m_axi4_fsb_reader: the bench plays the AXI slave and FSB consumer.
module tb_m_axi4_fsb_reader;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cfg_en;
    logic [63:0]  base;
    logic [10:0]  wr_ptr;
    logic [10:0]  rd_ptr;
    logic         err;
    logic [5:0]   arid;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [5:0]   rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [5:0]   awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [5:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic         fsb_v;
    logic [79:0]  fsb_data;
    logic         fsb_yumi;

    int checks = 0;
    int errors = 0;
    logic [511:0] beat_data [4];

    always #5 clk = ~clk;

    m_axi4_fsb_reader dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .cfg_en_i        (cfg_en),
        .cfg_base_addr_i (base),
        .cfg_wr_ptr_i    (wr_ptr),
        .rd_ptr_o        (rd_ptr),
        .err_o           (err),
        .m_axi_arid_o    (arid),
        .m_axi_araddr_o  (araddr),
        .m_axi_arlen_o   (arlen),
        .m_axi_arsize_o  (arsize),
        .m_axi_arburst_o (arburst),
        .m_axi_arvalid_o (arvalid),
        .m_axi_arready_i (arready),
        .m_axi_rid_i     (rid),
        .m_axi_rdata_i   (rdata),
        .m_axi_rresp_i   (rresp),
        .m_axi_rlast_i   (rlast),
        .m_axi_rvalid_i  (rvalid),
        .m_axi_rready_o  (rready),
        .m_axi_awid_o    (awid),
        .m_axi_awaddr_o  (awaddr),
        .m_axi_awlen_o   (awlen),
        .m_axi_awsize_o  (awsize),
        .m_axi_awburst_o (awburst),
        .m_axi_awvalid_o (awvalid),
        .m_axi_awready_i (awready),
        .m_axi_wdata_o   (wdata),
        .m_axi_wstrb_o   (wstrb),
        .m_axi_wlast_o   (wlast),
        .m_axi_wvalid_o  (wvalid),
        .m_axi_wready_i  (wready),
        .m_axi_bid_i     (bid),
        .m_axi_bresp_i   (bresp),
        .m_axi_bvalid_i  (bvalid),
        .m_axi_bready_o  (bready),
        .fsb_v_o         (fsb_v),
        .fsb_data_o      (fsb_data),
        .fsb_yumi_i      (fsb_yumi)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line with 80-bit payloads, junk in the pad bits, and per-slot valid flags
    function automatic logic [511:0] make_line(input logic [3:0] mask, input logic [79:0] t0,
                                               input logic [79:0] t1, input logic [79:0] t2,
                                               input logic [79:0] t3);
        logic [511:0] l;
        l = '0;
        l[79:0]    = t0;
        l[207:128] = t1;
        l[335:256] = t2;
        l[463:384] = t3;
        for (int i = 0; i < 4; i++) begin
            l[128*i + 80 +: 47] = {47{1'b1}};
            l[128*i + 127]      = mask[i];
        end
        return l;
    endfunction

    task automatic wait_ar(input string tag);
        int n;
        n = 0;
        while (arvalid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_arvalid"}, 512'(arvalid), 512'(1));
    endtask

    task automatic wait_v(input string tag);
        int n;
        n = 0;
        while (fsb_v !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_v"}, 512'(fsb_v), 512'(1));
    endtask

    // Expect one AR, then return beat_data[0..len-1]; bad_beat gets SLVERR
    task automatic serve_burst(input string tag, input logic [63:0] exp_addr, input int exp_len,
                               input int bad_beat);
        wait_ar(tag);
        check({tag, "_araddr"}, 512'(araddr), 512'(exp_addr));
        check({tag, "_arlen"}, 512'(arlen), 512'(exp_len - 1));
        tick();
        check({tag, "_ar_hold"}, 512'({arvalid, araddr}), 512'({1'b1, exp_addr}));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < exp_len; b++) begin
            rvalid = 1'b1;
            rdata  = beat_data[b];
            rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (b == exp_len - 1);
            check({tag, "_rready"}, 512'(rready), 512'(1));
            tick();
            if (b == bad_beat) check({tag, "_err_set"}, 512'(err), 512'(1));
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    // Accept whatever burst comes next and return empty lines
    task automatic serve_any();
        int len;
        wait_ar("ffwd");
        len = int'(arlen) + 1;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < len; b++) begin
            rvalid = 1'b1;
            rdata  = '0;
            rlast  = (b == len - 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic ffwd(input logic [10:0] target);
        wr_ptr = target;
        for (int k = 0; k < 400 && rd_ptr !== target; k++) serve_any();
        check("ffwd_rd_ptr", 512'(rd_ptr), 512'(target));
    endtask

    initial begin
        int arv;
        reset_n  = 1'b0;
        cfg_en   = 1'b0;
        base     = '0;
        wr_ptr   = '0;
        fsb_yumi = 1'b0;
        arready  = 1'b0;
        rid      = '0;
        rdata    = '0;
        rresp    = 2'b00;
        rlast    = 1'b0;
        rvalid   = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        bid      = '0;
        bresp    = 2'b00;
        bvalid   = 1'b0;
        for (int i = 0; i < 4; i++) beat_data[i] = '0;

        // Reset values
        tick();
        tick();
        check("rst_arvalid", 512'(arvalid), 512'(0));
        check("rst_rready", 512'(rready), 512'(0));
        check("rst_rd_ptr", 512'(rd_ptr), 512'(0));
        check("rst_err", 512'(err), 512'(0));
        check("rst_fsb_v", 512'(fsb_v), 512'(0));
        check("rst_fsb_data", 512'(fsb_data), 512'(0));
        reset_n = 1'b1;
        tick();

        // Single line: four valid slots, yumi held high
        base   = 64'h1000;
        wr_ptr = 11'd1;
        cfg_en = 1'b1;
        beat_data[0] = make_line(4'b1111, 80'hA, 80'hB, 80'hC, 80'hD);
        serve_burst("single", 64'h1000, 1, -1);
        check("single_rd_ptr", 512'(rd_ptr), 512'(1));
        check("single_v_lat1", 512'(fsb_v), 512'(0));
        tick();
        check("single_pkt_a", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'hA}));
        fsb_yumi = 1'b1;
        tick();
        check("single_pkt_b", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'hB}));
        tick();
        check("single_pkt_c", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'hC}));
        tick();
        check("single_pkt_d", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'hD}));
        tick();
        fsb_yumi = 1'b0;
        check("single_done_v", 512'(fsb_v), 512'(0));

        // Burst cap and page crossing from line 60
        for (int i = 0; i < 4; i++) beat_data[i] = '0;
        ffwd(11'd60);
        wr_ptr = 11'd70;
        serve_burst("pg0", 64'h1F00, 4, -1);
        check("pg0_rd_ptr", 512'(rd_ptr), 512'(64));
        serve_burst("pg1", 64'h2000, 4, -1);
        check("pg1_rd_ptr", 512'(rd_ptr), 512'(68));
        serve_burst("pg2", 64'h2100, 2, -1);
        check("pg2_rd_ptr", 512'(rd_ptr), 512'(70));

        // Ring wrap at index 1022
        ffwd(11'h3FE);
        wr_ptr = 11'h402;
        serve_burst("wrap0", 64'h10F80, 2, -1);
        check("wrap0_rd_ptr", 512'(rd_ptr), 512'(11'h400));
        serve_burst("wrap1", 64'h1000, 2, -1);
        check("wrap1_rd_ptr", 512'(rd_ptr), 512'(11'h402));
        check("wrap1_msb", 512'(rd_ptr[10]), 512'(1));

        // Sparse slots, an all-invalid line, then a single-slot line
        wr_ptr = 11'h405;
        beat_data[0] = make_line(4'b1010, 80'hEE, 80'h11, 80'hEE, 80'h33);
        beat_data[1] = make_line(4'b0000, 80'hEE, 80'hEE, 80'hEE, 80'hEE);
        beat_data[2] = make_line(4'b0001, 80'h55, 80'hEE, 80'hEE, 80'hEE);
        serve_burst("sparse", 64'h1080, 3, -1);
        check("sparse_rd_ptr", 512'(rd_ptr), 512'(11'h405));
        wait_v("sparse_s1");
        check("sparse_s1_data", 512'(fsb_data), 512'(80'h11));
        tick();
        check("sparse_s1_hold", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'h11}));
        fsb_yumi = 1'b1;
        tick();
        fsb_yumi = 1'b0;
        check("sparse_s3_data", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'h33}));
        tick();
        check("sparse_s3_hold", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'h33}));
        fsb_yumi = 1'b1;
        tick();
        fsb_yumi = 1'b0;
        check("sparse_line_end", 512'(fsb_v), 512'(0));
        wait_v("after_empty");
        check("after_empty_data", 512'(fsb_data), 512'(80'h55));
        fsb_yumi = 1'b1;
        tick();
        fsb_yumi = 1'b0;
        tick();
        check("after_empty_done", 512'(fsb_v), 512'(0));

        // SLVERR on beat 2 of 4
        for (int i = 0; i < 4; i++) beat_data[i] = '0;
        wr_ptr = 11'h409;
        serve_burst("err", 64'h1140, 4, 1);
        check("err_sticky", 512'(err), 512'(1));
        check("err_rd_ptr", 512'(rd_ptr), 512'(11'h405));
        arv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (arvalid) arv++;
        end
        check("err_no_ar", 512'(arv), 512'(0));
        check("err_held", 512'(err), 512'(1));
        cfg_en = 1'b0;
        tick();
        check("err_cleared", 512'(err), 512'(0));
        check("err_rd_ptr_kept", 512'(rd_ptr), 512'(11'h405));

        // FIFO backpressure: 20 lines available, yumi low
        wr_ptr = 11'h419;
        cfg_en = 1'b1;
        for (int i = 0; i < 4; i++)
            beat_data[i] = make_line(4'b0001, 80'(32'h105 + i), 80'h0, 80'h0, 80'h0);
        serve_burst("bp0", 64'h1140, 4, -1);
        for (int i = 0; i < 4; i++)
            beat_data[i] = make_line(4'b0001, 80'(32'h109 + i), 80'h0, 80'h0, 80'h0);
        serve_burst("bp1", 64'h1240, 4, -1);
        check("bp_rd_ptr", 512'(rd_ptr), 512'(11'h40D));
        arv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (arvalid) arv++;
        end
        check("bp_full_no_ar", 512'(arv), 512'(0));
        check("bp_head", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'h105}));
        fsb_yumi = 1'b1;
        tick();
        check("bp_pkt_106", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'h106}));
        tick();
        check("bp_pkt_107", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'h107}));
        tick();
        check("bp_pkt_108", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'h108}));
        tick();
        fsb_yumi = 1'b0;
        check("bp_pkt_109", 512'({fsb_v, fsb_data}), 512'({1'b1, 80'h109}));
        for (int i = 0; i < 4; i++) beat_data[i] = '0;
        serve_burst("bp2", 64'h1340, 4, -1);
        check("bp2_rd_ptr", 512'(rd_ptr), 512'(11'h411));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
